// File: rtl/hdc_sram_scheduler.sv
// rtl/hdc_sram_scheduler.sv - round-robin SRAM burst scheduler for three HDC encoder lanes
// Optional watchdog: define HDC_SCHED_TIMEOUT_EN to abort words stuck in FETCH.
module hdc_sram_scheduler #(
  parameter int ADDR_WIDTH     = 8,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic [2:0]              Req_SI,
  input  logic [3*ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [3*LEN_WIDTH-1:0]  ReqLen_DI,
  output logic [2:0]              Grant_SO,
  output logic [ADDR_WIDTH-1:0]   SramAddr_DO,
  output logic [8:0]              SramReq_SO,
  input  logic [8:0]              SramValid_SI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [2:0]              Done_SO,
  output logic                    Busy_SO,
  output logic                    Error_SO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            rr_q, rr_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            grant_q, grant_d;
  logic [2:0]            got_q, got_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [8:0]            sram_req_q, sram_req_d;

  logic                  win_found;
  logic [1:0]            win_lane;
  logic [2:0]            cand;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  win_len;
  logic [2:0]            lane_valid;
  logic [2:0]            got_new;
  logic                  all_got;
  logic                  timeout;

  // Search order rr, rr+1, rr+2 (mod 3); first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_lane  = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!win_found && Req_SI[cand[1:0]]) begin
        win_found = 1'b1;
        win_lane  = cand[1:0];
      end
    end
  end

  always_comb begin
    case (win_lane)
      2'd1: begin
        win_addr = ReqAddr_DI[ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = ReqLen_DI[LEN_WIDTH +: LEN_WIDTH];
      end
      2'd2: begin
        win_addr = ReqAddr_DI[2*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = ReqLen_DI[2*LEN_WIDTH +: LEN_WIDTH];
      end
      default: begin
        win_addr = ReqAddr_DI[0 +: ADDR_WIDTH];
        win_len  = ReqLen_DI[0 +: LEN_WIDTH];
      end
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd1:    lane_valid = SramValid_SI[5:3];
      2'd2:    lane_valid = SramValid_SI[8:6];
      default: lane_valid = SramValid_SI[2:0];
    endcase
  end

  // Valids landing in the same cycle as the request still count toward the word.
  assign got_new = got_q | lane_valid;
  assign all_got = &got_new;

`ifdef HDC_SCHED_TIMEOUT_EN
  localparam int WdWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdWidth-1:0] wd_q, wd_d;
  logic               error_q, error_d;

  assign timeout = (state_q == FETCH) && !all_got &&
                   (wd_q == WdWidth'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d    = '0;
    error_d = error_q | timeout;
    if (state_q == FETCH && state_d == FETCH) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign Error_SO = error_q;
`else
  assign timeout  = 1'b0;
  assign Error_SO = 1'b0;
`endif

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q    <= IDLE;
      rr_q       <= 2'd0;
      lane_q     <= 2'd0;
      grant_q    <= 3'd0;
      got_q      <= 3'd0;
      addr_q     <= '0;
      cnt_q      <= '0;
      sram_req_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lane_q     <= lane_d;
      grant_q    <= grant_d;
      got_q      <= got_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sram_req_q <= sram_req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = (win_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (timeout) begin
          state_d = DONE;
        end else if (all_got) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (ReadyIn_SI) begin
          state_d = (cnt_q <= LEN_WIDTH'(1)) ? DONE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d       = rr_q;
    lane_d     = lane_q;
    grant_d    = grant_q;
    got_d      = got_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sram_req_d = 9'd0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          lane_d  = win_lane;
          grant_d = 3'b001 << win_lane;
          addr_d  = win_addr;
          cnt_d   = win_len;
          got_d   = 3'd0;
        end
      end
      FETCH: begin
        got_d = timeout ? 3'd0 : got_new;
      end
      OUT: begin
        if (ReadyIn_SI) begin
          got_d = 3'd0;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (cnt_q > LEN_WIDTH'(1)) begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        grant_d = 3'd0;
        rr_d    = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;
      end
    endcase
    // Request lines are registered, so they are derived from the next-cycle view.
    if (state_d == FETCH) begin
      case (lane_d)
        2'd1:    sram_req_d[5:3] = ~got_d;
        2'd2:    sram_req_d[8:6] = ~got_d;
        default: sram_req_d[2:0] = ~got_d;
      endcase
    end
  end

  assign Grant_SO    = grant_q;
  assign SramAddr_DO = addr_q;
  assign SramReq_SO  = sram_req_q;
  assign ValidOut_SO = (state_q == OUT);
  assign Done_SO     = (state_q == DONE) ? grant_q : 3'd0;
  assign Busy_SO     = (state_q != IDLE);

endmodule

// File: tb/tb_hdc_sram_scheduler.sv
// tb/tb_hdc_sram_scheduler.sv - directed vector bench for hdc_sram_scheduler
// Build with HDC_SCHED_TIMEOUT_EN defined to exercise the watchdog path.
module tb_hdc_sram_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_addr;
  logic [23:0] req_len;
  logic [2:0]  grant;
  logic [7:0]  sram_addr;
  logic [8:0]  sram_req;
  logic [8:0]  sram_valid;
  logic        valid_out;
  logic        ready;
  logic [2:0]  done;
  logic        busy;
  logic        error;

  logic        echo;
  logic [8:0]  valid_man;

  int n_vec = 0;
  int n_err = 0;

  hdc_sram_scheduler #(
    .ADDR_WIDTH    (8),
    .LEN_WIDTH     (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk_CI      (clk),
    .Reset_RI    (rst),
    .Req_SI      (req),
    .ReqAddr_DI  (req_addr),
    .ReqLen_DI   (req_len),
    .Grant_SO    (grant),
    .SramAddr_DO (sram_addr),
    .SramReq_SO  (sram_req),
    .SramValid_SI(sram_valid),
    .ValidOut_SO (valid_out),
    .ReadyIn_SI  (ready),
    .Done_SO     (done),
    .Busy_SO     (busy),
    .Error_SO    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: either answers every request in the same cycle or follows valid_man.
  always_comb sram_valid = echo ? sram_req : valid_man;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [23:0] addr;
    logic [23:0] len;
    logic        ready;
    logic [2:0]  e_grant;
    logic [7:0]  e_addr;
    logic [8:0]  e_sreq;
    logic        e_vout;
    logic [2:0]  e_done;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [2:0] q, logic [23:0] a, logic [23:0] l, logic rd,
                              logic [2:0] eg, logic [7:0] ea, logic [8:0] es, logic ev,
                              logic [2:0] ed, logic eb);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.len = l; v.ready = rd;
    v.e_grant = eg; v.e_addr = ea; v.e_sreq = es; v.e_vout = ev; v.e_done = ed; v.e_busy = eb;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [2:0] eg, logic [7:0] ea, logic [8:0] es, logic ev,
                     logic [2:0] ed, logic eb, logic ee);
    n_vec++;
    if (grant !== eg) begin n_err++; $display("FAIL %s grant got %b want %b", nm, grant, eg); end
    if (sram_addr !== ea) begin n_err++; $display("FAIL %s addr got %h want %h", nm, sram_addr, ea); end
    if (sram_req !== es) begin n_err++; $display("FAIL %s sram_req got %h want %h", nm, sram_req, es); end
    if (valid_out !== ev) begin n_err++; $display("FAIL %s valid_out got %b want %b", nm, valid_out, ev); end
    if (done !== ed) begin n_err++; $display("FAIL %s done got %b want %b", nm, done, ed); end
    if (busy !== eb) begin n_err++; $display("FAIL %s busy got %b want %b", nm, busy, eb); end
    if (error !== ee) begin n_err++; $display("FAIL %s error got %b want %b", nm, error, ee); end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'd0; ready = 1'b1; valid_man = 9'd0;
    tick();
    chk("reset", 3'd0, 8'h00, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; req = 3'd0; req_addr = '0; req_len = '0; ready = 1'b1;
    echo = 1'b1; valid_man = 9'd0;

    // T1: single 4-word burst on lane 0, request dropped after grant
    add(1, 3'b000, 24'h000000, 24'h000000, 1, 3'b000, 8'h00, 9'h000, 0, 3'b000, 0);
    add(0, 3'b001, 24'h000010, 24'h000004, 1, 3'b001, 8'h10, 9'h007, 0, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h10, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h11, 9'h007, 0, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h11, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h12, 9'h007, 0, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h12, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h13, 9'h007, 0, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h13, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b001, 8'h13, 9'h000, 0, 3'b001, 1);
    add(0, 3'b000, 24'h000010, 24'h000004, 1, 3'b000, 8'h13, 9'h000, 0, 3'b000, 0);
    // T2: all lanes requesting, len=1 each, rr restarts at 0
    add(1, 3'b000, 24'h604020, 24'h010101, 1, 3'b000, 8'h00, 9'h000, 0, 3'b000, 0);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b001, 8'h20, 9'h007, 0, 3'b000, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b001, 8'h20, 9'h000, 1, 3'b000, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b001, 8'h20, 9'h000, 0, 3'b001, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b000, 8'h20, 9'h000, 0, 3'b000, 0);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b010, 8'h40, 9'h038, 0, 3'b000, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b010, 8'h40, 9'h000, 1, 3'b000, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b010, 8'h40, 9'h000, 0, 3'b010, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b000, 8'h40, 9'h000, 0, 3'b000, 0);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b100, 8'h60, 9'h1C0, 0, 3'b000, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b100, 8'h60, 9'h000, 1, 3'b000, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b100, 8'h60, 9'h000, 0, 3'b100, 1);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b000, 8'h60, 9'h000, 0, 3'b000, 0);
    add(0, 3'b111, 24'h604020, 24'h010101, 1, 3'b001, 8'h20, 9'h007, 0, 3'b000, 1);
    // T4: lane 2 wrapping burst, then zero-length burst on lane 0
    add(1, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b000, 8'h00, 9'h000, 0, 3'b000, 0);
    add(0, 3'b100, 24'hFE0000, 24'h040000, 1, 3'b100, 8'hFE, 9'h1C0, 0, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'hFE, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'hFF, 9'h1C0, 0, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'hFF, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'h00, 9'h1C0, 0, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'h00, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'h01, 9'h1C0, 0, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'h01, 9'h000, 1, 3'b000, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b100, 8'h01, 9'h000, 0, 3'b100, 1);
    add(0, 3'b000, 24'hFE0000, 24'h040000, 1, 3'b000, 8'h01, 9'h000, 0, 3'b000, 0);
    add(0, 3'b001, 24'h000033, 24'h000000, 1, 3'b001, 8'h33, 9'h000, 0, 3'b001, 1);
    add(0, 3'b000, 24'h000033, 24'h000000, 1, 3'b000, 8'h33, 9'h000, 0, 3'b000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req = tbl[i].req; req_addr = tbl[i].addr;
      req_len = tbl[i].len; ready = tbl[i].ready;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e_grant, tbl[i].e_addr, tbl[i].e_sreq,
          tbl[i].e_vout, tbl[i].e_done, tbl[i].e_busy, 1'b0);
    end

    // T3: staggered valids on lane 1, then backpressure in OUT
    do_reset();
    echo = 1'b0; req = 3'b010; req_addr = 24'h005000; req_len = 24'h000100;
    tick(); chk("t3_grant", 3'b010, 8'h50, 9'h038, 0, 3'b000, 1, 0);
    req = 3'b000;
    tick(); chk("t3_none", 3'b010, 8'h50, 9'h038, 0, 3'b000, 1, 0);
    valid_man = 9'h008;
    tick(); chk("t3_v0", 3'b010, 8'h50, 9'h030, 0, 3'b000, 1, 0);
    valid_man = 9'h009;
    tick(); chk("t3_ignored", 3'b010, 8'h50, 9'h030, 0, 3'b000, 1, 0);
    valid_man = 9'h010;
    tick(); chk("t3_v1", 3'b010, 8'h50, 9'h020, 0, 3'b000, 1, 0);
    valid_man = 9'h000;
    tick(); chk("t3_wait", 3'b010, 8'h50, 9'h020, 0, 3'b000, 1, 0);
    valid_man = 9'h020; ready = 1'b0;
    tick(); chk("t3_v2", 3'b010, 8'h50, 9'h000, 1, 3'b000, 1, 0);
    valid_man = 9'h000;
    for (int i = 0; i < 5; i++) begin
      tick(); chk($sformatf("t5_hold%0d", i), 3'b010, 8'h50, 9'h000, 1, 3'b000, 1, 0);
    end
    ready = 1'b1;
    tick(); chk("t3_done", 3'b010, 8'h50, 9'h000, 0, 3'b010, 1, 0);
    tick(); chk("t3_idle", 3'b000, 8'h50, 9'h000, 0, 3'b000, 0, 0);

    // T5: reset in the middle of a burst drops it without Done
    do_reset();
    echo = 1'b1; req = 3'b001; req_addr = 24'h000070; req_len = 24'h000004;
    tick(); chk("t5_fetch", 3'b001, 8'h70, 9'h007, 0, 3'b000, 1, 0);
    req = 3'b000;
    tick(); chk("t5_out", 3'b001, 8'h70, 9'h000, 1, 3'b000, 1, 0);
    tick(); chk("t5_fetch2", 3'b001, 8'h71, 9'h007, 0, 3'b000, 1, 0);
    rst = 1'b1;
    tick(); chk("t5_rst", 3'b000, 8'h00, 9'h000, 0, 3'b000, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("t5_after%0d", i), 3'b000, 8'h00, 9'h000, 0, 3'b000, 0, 0);
    end

    // T6: SRAM 2 of lane 0 never answers
    do_reset();
    echo = 1'b0; valid_man = 9'h003; req = 3'b001; req_addr = 24'h000090; req_len = 24'h000001;
    tick(); chk("t6_grant", 3'b001, 8'h90, 9'h007, 0, 3'b000, 1, 0);
    req = 3'b000;
`ifdef HDC_SCHED_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick(); chk($sformatf("t6_wait%0d", i), 3'b001, 8'h90, 9'h004, 0, 3'b000, 1, 0);
    end
    tick(); chk("t6_timeout", 3'b001, 8'h90, 9'h000, 0, 3'b001, 1, 1);
    tick(); chk("t6_sticky", 3'b000, 8'h90, 9'h000, 0, 3'b000, 0, 1);
    do_reset();
`else
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 3'b000) done_seen++;
    end
    n_vec++;
    if (done_seen != 0) begin
      n_err++;
      $display("FAIL t6_nodone done pulses got %0d want 0", done_seen);
    end
    chk("t6_stuck", 3'b001, 8'h90, 9'h004, 0, 3'b000, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
